// File: rtl/spi_rdid_ctrl_if.sv
// SPI bus between the RDID controller (master) and the serial flash (slave).
interface spi_rdid_ctrl_if;
   logic spi_clk;
   logic spi_mosi;
   logic spi_cs_n;
   logic spi_miso;

   modport master (output spi_clk, output spi_mosi, output spi_cs_n, input spi_miso);
   modport slave  (input spi_clk, input spi_mosi, input spi_cs_n, output spi_miso);
endinterface

// File: rtl/spi_rdid_ctrl.sv
// SPI mode-0 master that issues RDID (0x9F) and captures the 3-byte JEDEC ID.
// Optional manufacturer-ID check is built only when RDID_CHECK_EN is defined.
module spi_rdid_ctrl #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned CS_HOLD  = 2,
   parameter int unsigned CS_IDLE  = 5
`ifdef RDID_CHECK_EN
   ,
   parameter logic [7:0]  EXP_MAN_ID = 8'h20
`endif
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           clear,
   spi_rdid_ctrl_if.master spi,
   output logic           busy,
   output logic           done,
   output logic           id_valid,
   output logic [7:0]     man_id,
   output logic [7:0]     mem_type,
   output logic [7:0]     mem_cap,
   output logic           id_err
);

   localparam int unsigned BIT_PER = 2 * CLK_DIV;
   localparam int unsigned MAX_A   = (CS_SETUP > BIT_PER) ? CS_SETUP : BIT_PER;
   localparam int unsigned MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [7:0]  RDID_CMD = 8'h9F;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       bit_cnt;
   logic [23:0]      shift_q;
   logic             sclk_q;
   logic             mosi_q;
   logic             cs_n_q;

   assign spi.spi_clk  = sclk_q;
   assign spi.spi_mosi = mosi_q;
   assign spi.spi_cs_n = cs_n_q;

   // Command bits for bits 0-7, zero for the 24 response bits.
   function automatic logic cmd_bit(input logic [4:0] b);
      cmd_bit = (b[4:3] == 2'b00) ? RDID_CMD[3'd7 - b[2:0]] : 1'b0;
   endfunction

   // The SETUP state lasts CS_SETUP+1 cycles: the first is the cycle in which
   // cs_n has just fallen, which keeps done at 1+CS_SETUP+64*CLK_DIV+CS_HOLD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         id_valid <= 1'b0;
         man_id   <= 8'h00;
         mem_type <= 8'h00;
         mem_cap  <= 8'h00;
`ifdef RDID_CHECK_EN
         id_err   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (clear) begin
            id_valid <= 1'b0;
            man_id   <= 8'h00;
            mem_type <= 8'h00;
            mem_cap  <= 8'h00;
`ifdef RDID_CHECK_EN
            id_err   <= 1'b0;
`endif
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= SETUP;
                  cs_n_q <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= '0;
               end
            end
            SETUP: begin
               if (cnt == CNT_W'(CS_SETUP)) begin
                  state   <= SHIFT;
                  cnt     <= '0;
                  bit_cnt <= '0;
                  mosi_q  <= cmd_bit(5'd0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == CNT_W'(CLK_DIV - 1)) begin
                  sclk_q <= 1'b1;
                  cnt    <= cnt + 1'b1;
               end else if (cnt == CNT_W'(BIT_PER - 1)) begin
                  sclk_q <= 1'b0;
                  cnt    <= '0;
                  if (bit_cnt == 5'd31) begin
                     state  <= HOLD;
                     mosi_q <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     mosi_q  <= cmd_bit(bit_cnt + 5'd1);
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(CS_HOLD - 1)) begin
                  state    <= GAP;
                  cnt      <= '0;
                  cs_n_q   <= 1'b1;
                  done     <= 1'b1;
                  id_valid <= 1'b1;
                  man_id   <= shift_q[23:16];
                  mem_type <= shift_q[15:8];
                  mem_cap  <= shift_q[7:0];
`ifdef RDID_CHECK_EN
                  id_err   <= (shift_q[23:16] != EXP_MAN_ID);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == CNT_W'(CS_IDLE - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // MISO is taken on the edge that raises spi_clk; only response bits are kept.
   always_ff @(posedge clk) begin
      if (state == SHIFT && cnt == CNT_W'(CLK_DIV - 1) && bit_cnt[4:3] != 2'b00)
         shift_q <= {shift_q[22:0], spi.spi_miso};
   end

`ifndef RDID_CHECK_EN
   assign id_err = 1'b0;
`endif

endmodule
